alu_scheduler: RTL

Sequencer and arbiter that shares the single combinational `alu` between two requesters, for example the execute stage and the branch/address unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU operands and `aluSrc` for ops 0–7. It executes shift ops (8–10) itself with an iterative one-bit-per-cycle shifter, resolves `jr` (11) locally, and returns the tagged result over a valid/ready response channel.

---
 rtl/alu_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters; runs shifts iteratively and resolves jr.
// Define ALU_SCHED_RR_EN for round-robin tie-breaking (default: fixed priority, req0 wins).
module alu_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0Valid,
  output logic        req0Ready,
  input  logic [4:0]  req0Op,
  input  logic [31:0] req0A,
  input  logic [31:0] req0B,
  input  logic [4:0]  req0Shamt,
  input  logic        req1Valid,
  output logic        req1Ready,
  input  logic [4:0]  req1Op,
  input  logic [31:0] req1A,
  input  logic [31:0] req1B,
  input  logic [4:0]  req1Shamt,
  output logic [31:0] aluA,
  output logic [31:0] aluB,
  output logic [4:0]  aluSrc,
  input  logic [31:0] aluResult,
  output logic        respValid,
  input  logic        respReady,
  output logic        respId,
  output logic [31:0] respResult,
  output logic        respErr
);

  typedef enum logic [1:0] {StIdle, StAlu, StShift, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant;
  logic        accept;
  logic [4:0]  in_op;
  logic [4:0]  in_shamt;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  op_q;
  logic [4:0]  cnt_q;
  logic        id_q;
  logic        err_q;
  logic [31:0] result_q;
  logic [31:0] shift_next;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [4:0]  alu_src_q;

`ifdef ALU_SCHED_RR_EN
  logic last_q;

  // On a tie the requester not granted last wins; reset value makes req0 win the first tie.
  always_comb begin
    if (req0Valid && req1Valid) grant = ~last_q;
    else                        grant = ~req0Valid;
  end

  always_ff @(posedge clk) begin
    if (reset)       last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end
`else
  always_comb begin
    grant = ~req0Valid;
  end
`endif

  assign req0Ready = (state_q == StIdle) && !reset && req0Valid && !grant;
  assign req1Ready = (state_q == StIdle) && !reset && req1Valid && grant;
  assign accept    = req0Ready | req1Ready;

  assign in_op    = grant ? req1Op    : req0Op;
  assign in_a     = grant ? req1A     : req0A;
  assign in_b     = grant ? req1B     : req0B;
  assign in_shamt = grant ? req1Shamt : req0Shamt;

  always_comb begin
    shift_next = {result_q[30:0], 1'b0};
    if (op_q == 5'd9)       shift_next = {1'b0, result_q[31:1]};
    else if (op_q == 5'd10) shift_next = {result_q[31], result_q[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_op < 5'd8)                             state_d = StAlu;
          else if (in_op <= 5'd10 && in_shamt != 5'd0)  state_d = StShift;
          else                                          state_d = StResp;
        end
      end
      StAlu:   state_d = StResp;
      StShift: if (cnt_q == 5'd1) state_d = StResp;
      StResp:  if (respReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // result_q doubles as the shift working register; it is only exposed in StResp.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 5'd0;
      cnt_q     <= 5'd0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= 32'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_src_q <= 5'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= in_op;
            id_q  <= grant;
            err_q <= (in_op >= 5'd12);
            cnt_q <= in_shamt;
            if (in_op < 5'd8) begin
              alu_a_q   <= in_a;
              alu_b_q   <= in_b;
              alu_src_q <= in_op;
            end else if (in_op <= 5'd10) begin
              result_q <= in_b;
            end else if (in_op == 5'd11) begin
              result_q <= in_a;
            end else begin
              result_q <= 32'd0;
            end
          end
        end
        StAlu: result_q <= aluResult;
        StShift: begin
          result_q <= shift_next;
          cnt_q    <= cnt_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign aluA       = alu_a_q;
  assign aluB       = alu_b_q;
  assign aluSrc     = alu_src_q;
  assign respValid  = (state_q == StResp);
  assign respId     = id_q;
  assign respResult = result_q;
  assign respErr    = err_q;

endmodule
